// File: rtl/ps2_key_if.sv
// PS/2 keyboard receiver signal bundle: raw pins in, decoded key events out.
interface ps2_key_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       key_released;
  logic       key_extended;
  logic       frame_error;
  logic       rx_busy;

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output ps2_key_data, ps2_key_pressed, key_released, key_extended, frame_error, rx_busy
  );

  modport master (
    output PS2_CLK, PS2_DAT,
    input  ps2_key_data, ps2_key_pressed, key_released, key_extended, frame_error, rx_busy
  );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver with glitch filter, timeout and E0/F0 prefix decoding.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic     CLOCK_50,
  input  logic     reset,
  ps2_key_if.slave ps2
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic          clk_meta_reg, clk_sync_reg, dat_meta_reg, dat_sync_reg;
  logic          filt_level_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          filt_flip, fall_edge;
  logic [1:0]    state_reg;
  logic [3:0]    count_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] tmo_reg;
  logic          timeout_hit, frame_done, frame_ok, frame_bad;
  logic          ext_reg, brk_reg;
  logic [7:0]    key_data_reg;
  logic          pressed_reg, released_reg, key_ext_reg, ferr_reg;

  // Synchronisers reset to the idle bus level so reset never fakes an edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      {clk_meta_reg, clk_sync_reg, dat_meta_reg, dat_sync_reg} <= 4'b1111;
    end else begin
      clk_meta_reg <= ps2.PS2_CLK;
      clk_sync_reg <= clk_meta_reg;
      dat_meta_reg <= ps2.PS2_DAT;
      dat_sync_reg <= dat_meta_reg;
    end
  end

  // filt_cnt_reg counts consecutive synced samples differing from the filtered level.
  assign filt_flip = (clk_sync_reg != filt_level_reg) && (filt_cnt_reg == FW'(FILTER_LEN - 1));
  assign fall_edge = filt_flip && filt_level_reg;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt_level_reg <= 1'b1;
      filt_cnt_reg   <= '0;
    end else if (clk_sync_reg == filt_level_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_flip) begin
      filt_level_reg <= ~filt_level_reg;
      filt_cnt_reg   <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = !fall_edge && (count_reg != 4'd0) && (tmo_reg == TW'(TIMEOUT_CYCLES - 1));
  assign frame_done  = fall_edge && (state_reg == ST_STOP);
  assign frame_ok    = frame_done && (^{shift_reg, parity_reg}) && dat_sync_reg;
  assign frame_bad   = frame_done && !frame_ok;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= 4'd0;
      shift_reg  <= 8'd0;
      parity_reg <= 1'b0;
    end else if (timeout_hit) begin
      state_reg <= ST_IDLE;
      count_reg <= 4'd0;
    end else if (fall_edge) begin
      case (state_reg)
        ST_IDLE: begin
          if (!dat_sync_reg) begin
            count_reg <= 4'd1;
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          shift_reg <= {dat_sync_reg, shift_reg[7:1]};
          count_reg <= count_reg + 4'd1;
          if (count_reg == 4'd8) state_reg <= ST_PARITY;
        end
        ST_PARITY: begin
          parity_reg <= dat_sync_reg;
          count_reg  <= count_reg + 4'd1;
          state_reg  <= ST_STOP;
        end
        default: begin
          count_reg <= 4'd0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || fall_edge || (count_reg == 4'd0) || timeout_hit) tmo_reg <= '0;
    else tmo_reg <= tmo_reg + 1'b1;
  end

  // Prefix bytes only arm flags; any other outcome of a frame consumes them.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ext_reg      <= 1'b0;
      brk_reg      <= 1'b0;
      key_data_reg <= 8'd0;
      key_ext_reg  <= 1'b0;
      pressed_reg  <= 1'b0;
      released_reg <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      pressed_reg  <= 1'b0;
      released_reg <= 1'b0;
      ferr_reg     <= 1'b0;
      if (frame_bad || timeout_hit) begin
        ferr_reg <= 1'b1;
        ext_reg  <= 1'b0;
        brk_reg  <= 1'b0;
      end else if (frame_ok) begin
        if (shift_reg == 8'hE0) begin
          ext_reg <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          brk_reg <= 1'b1;
        end else begin
          if (brk_reg) released_reg <= 1'b1;
          else pressed_reg <= 1'b1;
          key_data_reg <= shift_reg;
          key_ext_reg  <= ext_reg;
          ext_reg      <= 1'b0;
          brk_reg      <= 1'b0;
        end
      end
    end
  end

  assign ps2.ps2_key_data    = key_data_reg;
  assign ps2.ps2_key_pressed = pressed_reg;
  assign ps2.key_released    = released_reg;
  assign ps2.key_extended    = key_ext_reg;
  assign ps2.frame_error     = ferr_reg;
  assign ps2.rx_busy         = (count_reg != 4'd0);
endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed and randomized PS/2 frames checked against an event-level reference model.
module tb_ps2_key_receiver;
  localparam int HALF = 20;

  logic CLOCK_50 = 1'b0;
  logic reset;
  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_key_if ifc ();

  ps2_key_receiver #(.FILTER_LEN(2), .TIMEOUT_CYCLES(200)) u_dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .ps2     (ifc)
  );

  int checks = 0;
  int errors = 0;

  // Event word: {kind[1:0], ext, data[7:0]}; kind 1=press, 2=release, 3=frame error.
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [7:0]  model_data;
  logic        model_ext, model_pfx_ext, model_pfx_brk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (ifc.ps2_key_pressed) obs_q.push_back({21'd0, 2'd1, ifc.key_extended, ifc.ps2_key_data});
      if (ifc.key_released)    obs_q.push_back({21'd0, 2'd2, ifc.key_extended, ifc.ps2_key_data});
      if (ifc.frame_error)     obs_q.push_back({21'd0, 2'd3, 1'b0, 8'd0});
    end
  end

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      ifc.PS2_DAT = bits[i];
      repeat (HALF) @(negedge CLOCK_50);
      ifc.PS2_CLK = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      ifc.PS2_CLK = 1'b1;
    end
    ifc.PS2_DAT = 1'b1;
  endtask

  task automatic model_error();
    exp_q.push_back({21'd0, 2'd3, 1'b0, 8'd0});
    model_pfx_ext = 1'b0;
    model_pfx_brk = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic valid);
    if (!valid) model_error();
    else if (b == 8'hE0) model_pfx_ext = 1'b1;
    else if (b == 8'hF0) model_pfx_brk = 1'b1;
    else begin
      exp_q.push_back({21'd0, model_pfx_brk ? 2'd2 : 2'd1, model_pfx_ext, b});
      model_data    = b;
      model_ext     = model_pfx_ext;
      model_pfx_ext = 1'b0;
      model_pfx_brk = 1'b0;
    end
  endtask

  task automatic expect_events(input string tag);
    logic [31:0] o, e;
    repeat (30) @(negedge CLOCK_50);
    $display("txn %s: %0d events observed, %0d expected", tag, obs_q.size(), exp_q.size());
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_event"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_data"}, ifc.ps2_key_data, model_data);
    check({tag, "_ext"}, ifc.key_extended, model_ext);
  endtask

  task automatic frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input string tag);
    send_bits(make_frame(b, bad_par, bad_stop), 11);
    model_frame(b, !(bad_par || bad_stop));
    expect_events(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, ifc.ps2_key_data, 8'd0);
    check({tag, "_pressed"}, ifc.ps2_key_pressed, 1'b0);
    check({tag, "_released"}, ifc.key_released, 1'b0);
    check({tag, "_ext"}, ifc.key_extended, 1'b0);
    check({tag, "_ferr"}, ifc.frame_error, 1'b0);
    check({tag, "_busy"}, ifc.rx_busy, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    reset = 1'b1;
    ifc.PS2_CLK = 1'b1;
    ifc.PS2_DAT = 1'b1;
    model_data = 8'd0; model_ext = 1'b0; model_pfx_ext = 1'b0; model_pfx_brk = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check_idle_outputs("reset");
    reset = 1'b0;

    frame(8'h5A, 1'b0, 1'b0, "t1_5A");
    frame(8'hF0, 1'b0, 1'b0, "t2_F0");
    frame(8'h5A, 1'b0, 1'b0, "t2_5A_break");
    frame(8'hE0, 1'b0, 1'b0, "t3_E0");
    frame(8'h75, 1'b0, 1'b0, "t3_75_ext");
    frame(8'hE0, 1'b0, 1'b0, "t3_E0b");
    frame(8'hF0, 1'b0, 1'b0, "t3_F0b");
    frame(8'h75, 1'b0, 1'b0, "t3_75_extbreak");
    frame(8'h5A, 1'b1, 1'b0, "t4_badpar");
    frame(8'h29, 1'b0, 1'b0, "t4_29");
    frame(8'h33, 1'b0, 1'b1, "t4_badstop");

    // One-cycle low glitch on the clock pin must be filtered out.
    @(negedge CLOCK_50);
    ifc.PS2_CLK = 1'b0;
    @(negedge CLOCK_50);
    ifc.PS2_CLK = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("t5_glitch_busy", ifc.rx_busy, 1'b0);
    expect_events("t5_glitch");

    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 4);
    repeat (10) @(negedge CLOCK_50);
    check("t5_partial_busy", ifc.rx_busy, 1'b1);
    repeat (240) @(negedge CLOCK_50);
    check("t5_timeout_busy", ifc.rx_busy, 1'b0);
    model_error();
    expect_events("t5_timeout");
    frame(8'h1C, 1'b0, 1'b0, "t5_1C");

    send_bits(make_frame(8'h5A, 1'b0, 1'b0), 5);
    repeat (10) @(negedge CLOCK_50);
    check("t6_partial_busy", ifc.rx_busy, 1'b1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check_idle_outputs("t6_after_reset");
    model_data = 8'd0; model_ext = 1'b0; model_pfx_ext = 1'b0; model_pfx_brk = 1'b0;
    exp_q.delete();
    repeat (250) @(negedge CLOCK_50);
    expect_events("t6_gap");
    frame(8'h1C, 1'b0, 1'b0, "t6_1C");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      r = $urandom_range(0, 11);
      frame(b, r == 0, r == 1, $sformatf("rand%0d_%02h", i, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
